bram_port_sched: RTL and testbench
==================================

BRAM_PORT_SCHED -- requirements
Module: bram_port_sched

Interface
REQ-001 Parameter FETCH_MAXWAIT, default 4, range 1-7: consecutive denied fetch cycles before fetch is forced priority.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserting clears all state immediately, deassertion is synchronous to clk.
REQ-004 if_req  in  1  fetch stage requests an instruction read this cycle.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 d_req  in  1  MEM stage requests a data access this cycle.
REQ-007 d_we  in  1  1 = store, 0 = load; qualified by d_req.
REQ-008 d_addr  in  32  data byte address.
REQ-009 d_wdata  in  32  store data.
REQ-010 d_be  in  4  store byte enables.
REQ-011 flush  in  1  branch redirect; kills any in-flight fetch read.
REQ-012 bram_en  out  1  single-port BRAM enable.
REQ-013 bram_we  out  4  BRAM byte write enables.
REQ-014 bram_addr  out  32  BRAM byte address.
REQ-015 bram_wdata  out  32  BRAM write data.
REQ-016 bram_rdata  in  32  BRAM read data, valid one cycle after a read enable.
REQ-017 if_gnt / d_gnt  out  1 each  request accepted this cycle.
REQ-018 if_rvalid / d_rvalid  out  1 each  read data returned this cycle.
REQ-019 if_rdata / d_rdata  out  32 each  equal to bram_rdata; meaningful only with matching rvalid.
REQ-020 stall_f  out  1  freeze PC and IF/ID register; stall_m  out  1  freeze EX/MEM and hold MEM/WB register.

Function
REQ-021 Grant is combinational in the request cycle; at most one of if_gnt, d_gnt high per cycle.
REQ-022 Default priority: data over fetch (older instruction wins).
REQ-023 Starvation counter (3 bits) increments each cycle if_req=1 and if_gnt=0; clears on if_gnt or if_req=0; saturates at FETCH_MAXWAIT.
REQ-024 When counter == FETCH_MAXWAIT and if_req=1, fetch wins over data for that cycle.
REQ-025 Granted cycle: bram_en=1, bram_addr = granted address; store drives bram_we=d_be, bram_wdata=d_wdata; reads drive bram_we=0.
REQ-026 No grant: bram_en=0, bram_we=0, bram_addr and bram_wdata hold last driven value.
REQ-027 In-flight register records owner of a read granted in cycle N (none/IF/D); corresponding rvalid asserts exactly in cycle N+1, never otherwise.
REQ-028 Store: completes in grant cycle; no rvalid produced.
REQ-029 Back-to-back reads permitted: new grant in N+1 while rvalid for N is returned; no idle cycle inserted.
REQ-030 flush=1 in cycle N: if_rvalid forced 0 in N; fetch read granted in N still issues but its if_rvalid in N+1 is suppressed; d_rvalid unaffected.
REQ-031 stall_f = if_req and not if_gnt; stall_m = d_req and not d_gnt (combinational).
REQ-032 if_req and d_req both 0: no state change except counter clear.

Reset
REQ-033 While reset=0: all outputs 0, starvation counter 0, in-flight owner none.
REQ-034 Read granted in the cycle reset asserts is discarded; no rvalid after reset deasserts.
REQ-035 First cycle after deassertion arbitrates normally with counter 0.

Verification
REQ-036 Load only: d_req=1,d_we=0,d_addr=0x10, BRAM holds 0xDEADBEEF -> d_gnt cycle N, d_rvalid=1,d_rdata=0xDEADBEEF in N+1.
REQ-037 Simultaneous if_req and store (d_be=0xF, d_wdata=0x12345678) -> d_gnt=1, bram_we=0xF, stall_f=1; fetch granted next cycle, if_rvalid one cycle later.
REQ-038 Continuous d_req and if_req for 8 cycles, FETCH_MAXWAIT=4 -> fetch denied 4 cycles, granted 5th, counter clears, pattern repeats.
REQ-039 Fetch granted in N with flush=1 in N -> if_rvalid=0 in N+1; fetch granted in N+1 without flush returns if_rvalid in N+2.
REQ-040 reset=0 asserted in cycle after load grant -> d_rvalid stays 0, all outputs 0 during and after reset until a new grant.
REQ-041 Alternating load/fetch every cycle -> continuous bram_en=1, rvalid toggles between d and if, no lost or duplicated response.

Source files
------------

// File: rtl/bram_port_sched.sv
// bram_port_sched
// Arbitrates one single-port BRAM between the instruction-fetch stage and the
// MEM stage. Data accesses win by default. A fetch that has been denied
// FETCH_MAXWAIT consecutive cycles wins the next cycle it still requests.
// Read data comes back one cycle after the grant, on the rvalid of the port
// that owned the read.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   if_req, if_addr             fetch read request
//   d_req, d_we, d_addr,
//   d_wdata, d_be               data load/store request
//   flush                       branch redirect, kills the fetch read in flight
//   bram_en/we/addr/wdata       BRAM command
//   bram_rdata                  BRAM read data (one-cycle latency)
//   if_gnt, d_gnt               request accepted this cycle
//   if_rvalid/if_rdata,
//   d_rvalid/d_rdata            read responses
//   stall_f, stall_m            pipeline freezes while a request is denied
//
// In-flight owner states
//   state    | meaning
//   OWN_NONE | no read issued last cycle (or it was a store / killed fetch)
//   OWN_IF   | fetch read issued last cycle, response due now
//   OWN_D    | data load issued last cycle, response due now
module bram_port_sched #(
    parameter int unsigned FETCH_MAXWAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    input  logic        flush,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    input  logic [31:0] bram_rdata,
    output logic        if_gnt,
    output logic        d_gnt,
    output logic        if_rvalid,
    output logic        d_rvalid,
    output logic [31:0] if_rdata,
    output logic [31:0] d_rdata,
    output logic        stall_f,
    output logic        stall_m
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [2:0] MAXW = 3'(FETCH_MAXWAIT);

    owner_t      owner_q, owner_d;
    logic [2:0]  starv_q, starv_d;
    logic [31:0] addr_q, wdata_q;
    logic        fetch_force, if_win, d_win, d_store;

    // Grants are qualified by reset so every output reads 0 while it is held.
    always_comb begin
        fetch_force = if_req && (starv_q == MAXW);
        if_win      = reset && if_req && (!d_req || fetch_force);
        d_win       = reset && d_req && !if_win;
        d_store     = d_win && d_we;
    end

    always_comb begin
        owner_d = OWN_NONE;
        starv_d = 3'd0;
        // A fetch granted together with flush is issued but never answered.
        if (if_win && !flush) begin
            owner_d = OWN_IF;
        end else if (d_win && !d_we) begin
            owner_d = OWN_D;
        end
        if (if_req && !if_win) begin
            starv_d = (starv_q < MAXW) ? starv_q + 3'd1 : MAXW;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
            starv_q <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            owner_q <= owner_d;
            starv_q <= starv_d;
            if (if_win || d_win) begin
                addr_q <= if_win ? if_addr : d_addr;
            end
            if (d_store) begin
                wdata_q <= d_wdata;
            end
        end
    end

    // Address and write data hold their last driven value between grants.
    always_comb begin
        if_gnt     = if_win;
        d_gnt      = d_win;
        bram_en    = if_win || d_win;
        bram_we    = d_store ? d_be : 4'd0;
        bram_addr  = if_win ? if_addr : (d_win ? d_addr : addr_q);
        bram_wdata = d_store ? d_wdata : wdata_q;
        if_rvalid  = (owner_q == OWN_IF) && !flush;
        d_rvalid   = (owner_q == OWN_D);
        if_rdata   = reset ? bram_rdata : 32'd0;
        d_rdata    = reset ? bram_rdata : 32'd0;
        stall_f    = reset && if_req && !if_win;
        stall_m    = reset && d_req && !d_win;
    end

endmodule

// File: tb/tb_bram_port_sched.sv
module tb_bram_port_sched;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, flush = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr, bram_wdata;
    logic [31:0] bram_rdata = '0;
    logic        if_gnt, d_gnt, if_rvalid, d_rvalid, stall_f, stall_m;
    logic [31:0] if_rdata, d_rdata;

    bram_port_sched #(.FETCH_MAXWAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .flush(flush),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .if_gnt(if_gnt), .d_gnt(d_gnt), .if_rvalid(if_rvalid), .d_rvalid(d_rvalid),
        .if_rdata(if_rdata), .d_rdata(d_rdata), .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_if;
        logic [31:0] data;
    } resp_t;

    resp_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int          waited = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // BRAM behaviour driven purely by the DUT's command outputs.
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we != 4'd0) mem[bram_addr[5:2]] <= merge(mem[bram_addr[5:2]], bram_wdata, bram_we);
            else                 bram_rdata <= mem[bram_addr[5:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One arbitration cycle: drive, compare against the reference rules, advance the model.
    task automatic cycle(input bit ireq, input logic [31:0] iaddr, input bit dreq, input bit dwe,
                         input logic [31:0] daddr, input logic [31:0] wd, input logic [3:0] be,
                         input bit fl);
        bit          eig, edg;
        logic [31:0] eaddr;
        resp_t       r;
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        if_req = ireq; if_addr = iaddr; d_req = dreq; d_we = dwe;
        d_addr = daddr; d_wdata = wd; d_be = be; flush = fl;
        if (fl) begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].is_if && q[i].cyc == cyc) q.delete(i);
        end
        #1;
        eig   = ireq && (!dreq || waited >= MAXW);
        edg   = dreq && !eig;
        eaddr = eig ? iaddr : (edg ? daddr : last_addr);
        chk("if_gnt", 32'(if_gnt), 32'(eig));
        chk("d_gnt", 32'(d_gnt), 32'(edg));
        chk("bram_en", 32'(bram_en), 32'(eig || edg));
        chk("bram_addr", bram_addr, eaddr);
        chk("bram_we", 32'(bram_we), (edg && dwe) ? 32'(be) : 32'd0);
        chk("bram_wdata", bram_wdata, (edg && dwe) ? wd : last_wdata);
        chk("stall_f", 32'(stall_f), 32'(ireq && !eig));
        chk("stall_m", 32'(stall_m), 32'(dreq && !edg));
        if (eig && !fl) begin
            r.cyc = cyc + 1; r.is_if = 1'b1; r.data = ref_mem[iaddr[5:2]];
            q.push_back(r);
        end
        if (edg && !dwe) begin
            r.cyc = cyc + 1; r.is_if = 1'b0; r.data = ref_mem[daddr[5:2]];
            q.push_back(r);
        end
        if (edg && dwe) begin
            ref_mem[daddr[5:2]] = merge(ref_mem[daddr[5:2]], wd, be);
            last_wdata = wd;
        end
        if (eig || edg) last_addr = eaddr;
        waited = (ireq && !eig) ? ((waited < MAXW) ? waited + 1 : MAXW) : 0;
    endtask

    task automatic idle();
        cycle(0, 32'd0, 0, 0, 32'd0, 32'd0, 4'd0, 0);
    endtask

    // Reset held low with requests driven: everything must read 0.
    task automatic reset_cycle();
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = $urandom_range(0, 1);
        if_addr = 32'h24; d_addr = 32'h28; d_wdata = $urandom; d_be = 4'hF; flush = 1'b0;
        q.delete();
        waited = 0; last_addr = '0; last_wdata = '0;
        #1;
        chk("rst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", bram_addr, 32'd0);
        chk("rst_bram_wdata", bram_wdata, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_stall", {30'd0, stall_f, stall_m}, 32'd0);
    endtask

    // Monitor: every rvalid must match the oldest expected response, in its cycle.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (if_rvalid || d_rvalid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_rvalid cyc=%0d actual if=%0b d=%0b required none",
                             cyc, if_rvalid, d_rvalid);
                end else begin
                    r = q.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(r.cyc));
                    chk("resp_if_rvalid", 32'(if_rvalid), 32'(r.is_if));
                    chk("resp_d_rvalid", 32'(d_rvalid), 32'(!r.is_if));
                    chk("resp_data", r.is_if ? if_rdata : d_rdata, r.data);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                r = q.pop_front();
                total++; bad++;
                $display("FAIL missing_rvalid cyc=%0d actual none required %s response due cyc %0d",
                         cyc, r.is_if ? "if" : "d", r.cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        reset_cycle();
        reset_cycle();
        idle();

        // Load 0x10 -> DEADBEEF the next cycle.
        cycle(0, 32'd0, 1, 0, 32'h10, 32'd0, 4'd0, 0);
        idle();
        chk("load_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("load_d_rdata", d_rdata, 32'hDEADBEEF);

        // Store collides with fetch; fetch follows, response after.
        cycle(1, 32'h20, 1, 1, 32'h08, 32'h12345678, 4'hF, 0);
        cycle(1, 32'h20, 0, 0, 32'd0, 32'd0, 4'd0, 0);
        idle();
        chk("fetch_after_store_rvalid", 32'(if_rvalid), 32'd1);

        // Continuous contention: fetch wins every fifth cycle.
        idle();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h30, 1, 0, 32'h14, 32'd0, 4'd0, 0);
            chk("starve_pattern", 32'(if_gnt), 32'(i % 5 == 4));
        end
        idle();

        // Flush on the grant cycle kills that response only.
        cycle(1, 32'h04, 0, 0, 32'd0, 32'd0, 4'd0, 1);
        cycle(1, 32'h0C, 0, 0, 32'd0, 32'd0, 4'd0, 0);
        chk("flushed_no_rvalid", 32'(if_rvalid), 32'd0);
        idle();
        chk("unflushed_rvalid", 32'(if_rvalid), 32'd1);

        // Reset right after a load grant discards its response.
        cycle(0, 32'd0, 1, 0, 32'h10, 32'd0, 4'd0, 0);
        reset_cycle();
        reset_cycle();
        idle();
        idle();

        // Alternating load / fetch keeps the BRAM busy every cycle.
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) cycle(0, 32'd0, 1, 0, 32'(i * 4), 32'd0, 4'd0, 0);
            else            cycle(1, 32'(i * 4), 0, 0, 32'd0, 32'd0, 4'd0, 0);
        end
        idle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 70, {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                  {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                  4'($urandom_range(1, 15)), $urandom_range(0, 99) < 10);
        end
        idle();
        idle();
        idle();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual timeout required finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
